ext_arith_call: RTL
===================

# ext_arith_call

External-call arithmetic unit for scheduled (FSM-generated) designs. It is a parametrised successor to the single-shot hello-style external module. A caller holds `req_valid` and arguments stable. The block computes one of four operations with an op-dependent latency, then returns the result on `z` with a one-cycle `req_ready` acknowledge. It also keeps a running accumulator and a saturating call counter.

## Interface
- `WIDTH`, 32: data width of `x`, `y`, `z` and the accumulator.
- `MUL_STAGES`, 3: latency of MUL in clock edges. Must be ≥1.
- `CNT_WIDTH`, 16: width of `call_count`.

Reset and clocking (decided): one clock, `clk`. Reset is `rst`, asynchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  1  call request; the caller holds it high, with args stable, until it sees `req_ready`.
- `req_op`  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 ACC.
- `x`  in  WIDTH  argument 0.
- `y`  in  WIDTH  argument 1; ignored by ACC.
- `acc_clr`  in  1  synchronous accumulator clear.
- `req_ready`  out  1  one-cycle acknowledge; `z` is valid in this cycle.
- `z`  out  WIDTH  result register; holds the last result until the next response.
- `busy`  out  1  high in every state except IDLE.
- `call_count`  out  CNT_WIDTH  number of completed calls; saturates.

## Operation
States:
- **IDLE**
  - If `req_valid`=1 at an edge: latch `req_op`, `x`, `y`.
  - Load latency counter with L-1, where L=1 for ADD/SUB/ACC and L=`MUL_STAGES` for MUL.
  - Go to BUSY.
- **BUSY**
  - Counter ≠0: decrement.
  - Counter =0: register the result into `z`, go to RESP, increment `call_count` unless it is at all-ones.
- **RESP**
  - `req_ready`=1 for exactly this cycle.
  - Next edge: go to WAIT_DROP.
- **WAIT_DROP**
  - Stay while `req_valid`=1.
  - Go to IDLE at the first edge with `req_valid`=0.
  - This prevents a held request from being executed twice.

Arithmetic (all mod 2^WIDTH, using latched operands):
- ADD: x+y.
- SUB: x-y (wraps).
- MUL: low WIDTH bits of x*y. May be implemented as a MUL_STAGES-deep pipeline; it is never overlapped, since only one call is outstanding.
- ACC: `acc` ← `acc`+x, and `z` ← the new `acc`.

Accumulator clear:
- `acc_clr`=1 at any edge sets `acc` to 0.
- If this coincides with an ACC result edge, the clear wins: `acc`=0, and `z` gets `acc`+x computed before the clear.
- `acc_clr` never affects `z` or `call_count`.

Inputs outside IDLE: changes to `req_op`, `x`, `y` while not in IDLE are ignored.

Reset (asynchronous, any state, including mid-MUL):
- State → IDLE.
- `req_ready`=0, `z`=0, `busy`=0, `call_count`=0, `acc`=0, latency counter=0.
- An aborted call produces no response.

## Timing
- Accepting edge E0: the first edge with `req_valid`=1 in IDLE.
- `busy` rises after E0.
- `z` updates and `req_ready` rises after edge E(L):
  - L=1 for ADD/SUB/ACC;
  - L=`MUL_STAGES` for MUL.
- `req_ready` falls after E(L+1).
- Fastest repeat: the caller drops `req_valid` in the cycle after `req_ready`. The block reaches IDLE at E(L+2) and can accept a new request at E(L+3). Turnaround is L+3 cycles per call.
- `req_ready` and `z` are register outputs; there is no combinational path from inputs.
- `call_count` at all-ones stays all-ones; it never wraps.
- `req_valid` deasserted during BUSY: the call still completes and responds, then the block returns to IDLE via WAIT_DROP.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req_valid`=1. Required: all outputs 0 asynchronously; after release, no `req_ready` until a fresh accept.
- **ADD/SUB wrap:**
  - ADD x=0xFFFFFFFF, y=2 → `z`=0x00000001, `req_ready` one cycle after E1.
  - SUB x=1, y=2 → `z`=0xFFFFFFFF.
  - `call_count`=2.
- **MUL:** x=0x00010000, y=0x00030001 → `z`=0x00010000 (truncated), with `req_ready` after E3. Then assert `rst` during BUSY of a second MUL → no response, `call_count`=0.
- **ACC + clear:**
  - ACC x=5, then ACC x=7 → `z`=5, then 12.
  - ACC x=3 with `acc_clr` on its result edge → `z`=15.
  - Next ACC x=1 → `z`=1.
- **Held request:** keep `req_valid`=1 for 10 cycles after `req_ready`. Required: exactly one response and `call_count`=1; the block returns to IDLE on the first edge with `req_valid` low.
- **Saturation:** with `CNT_WIDTH`=2, perform 5 calls → `call_count`=3.

Source files
------------

// File: rtl/ext_arith_call.sv
// External-call arithmetic unit: ADD/SUB/MUL/ACC with op-dependent latency,
// one-cycle req_ready acknowledge, running accumulator and saturating call counter.
module ext_arith_call #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [1:0]           req_op,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 acc_clr,
   output logic                 req_ready,
   output logic [WIDTH-1:0]     z,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] call_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      RESP      = 2'd2,
      WAIT_DROP = 2'd3
   } state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_ACC = 2'd3;

   localparam int LAT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
   localparam logic [LAT_W-1:0] MUL_LAT = LAT_W'(MUL_STAGES - 1);

   state_t               state_r;
   state_t               next_s;
   logic                 done_s;
   logic [1:0]           op_r;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     b_r;
   logic [LAT_W-1:0]     cnt_r;
   logic [WIDTH-1:0]     acc_r;
   logic [WIDTH-1:0]     acc_sum_s;
   logic [WIDTH-1:0]     mul_s;
   logic [WIDTH-1:0]     result_s;
   logic                 req_ready_r;
   logic                 busy_r;
   logic [WIDTH-1:0]     z_r;
   logic [CNT_WIDTH-1:0] count_r;

   // Next-state decode; done_s marks the edge that registers the result
   always_comb begin
      next_s = state_r;
      done_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               next_s = BUSY;
            end else begin
               next_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == {LAT_W{1'b0}}) begin
               next_s = RESP;
               done_s = 1'b1;
            end else begin
               next_s = BUSY;
            end
         end
         RESP: begin
            next_s = WAIT_DROP;
         end
         WAIT_DROP: begin
            if (req_valid) begin
               next_s = WAIT_DROP;
            end else begin
               next_s = IDLE;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // Result mux over the latched operands; only the low WIDTH bits of the product are kept
   always_comb begin
      acc_sum_s = acc_r + a_r;
      mul_s     = a_r * b_r;
      result_s  = a_r + b_r;
      case (op_r)
         OP_ADD:  result_s = a_r + b_r;
         OP_SUB:  result_s = a_r - b_r;
         OP_MUL:  result_s = mul_s;
         OP_ACC:  result_s = acc_sum_s;
         default: result_s = a_r + b_r;
      endcase
   end

   // State, operand latch, latency counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         op_r        <= 2'd0;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         cnt_r       <= {LAT_W{1'b0}};
         req_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         z_r         <= {WIDTH{1'b0}};
         count_r     <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r     <= next_s;
         req_ready_r <= done_s;
         busy_r      <= (next_s != IDLE);
         if (state_r == IDLE && req_valid) begin
            op_r  <= req_op;
            a_r   <= x;
            b_r   <= y;
            cnt_r <= (req_op == OP_MUL) ? MUL_LAT : {LAT_W{1'b0}};
         end else if (state_r == BUSY && cnt_r != {LAT_W{1'b0}}) begin
            cnt_r <= cnt_r - LAT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (done_s) begin
            z_r <= result_s;
            if (count_r != {CNT_WIDTH{1'b1}}) begin
               count_r <= count_r + CNT_WIDTH'(1);
            end else begin
               count_r <= count_r;
            end
         end else begin
            z_r <= z_r;
         end
      end
   end

   // Accumulator: a clear on the ACC result edge wins, while z still takes the pre-clear sum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {WIDTH{1'b0}};
      end else if (acc_clr) begin
         acc_r <= {WIDTH{1'b0}};
      end else if (done_s && op_r == OP_ACC) begin
         acc_r <= acc_sum_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign req_ready  = req_ready_r;
   assign busy       = busy_r;
   assign z          = z_r;
   assign call_count = count_r;

endmodule
